spi_flash_arb: RTL

Owns the single SPI flash pad set in the ice40 stub. It sequences flash power-up by issuing a release-from-deep-power-down (0xAB) command and waiting tRES1. It then shares the bus between requesters, for example flash_lock and a future flash-read/DFU engine, using transaction-level round-robin with an enforced CS-high gap between owners. No requester touches pads directly.

---
 rtl/spi_flash_arb_pkg.sv | 28 ++
 rtl/spi_flash_arb_rr_pick.sv | 31 +++
 rtl/spi_flash_arb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_flash_arb_pkg.sv
// Shared types and constants for the SPI flash pad arbiter.
package spi_flash_arb_pkg;

  typedef enum logic [2:0] {
    ST_WAKE_CMD,
    ST_WAKE_WAIT,
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } state_t;

  // Release-from-deep-power-down opcode.
  localparam logic [7:0] WAKE_OPCODE_DEF = 8'hAB;

  // Half-clock steps used to shift one opcode byte (8 bits x 2 phases).
  localparam int unsigned WAKE_CMD_STEPS = 16;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/spi_flash_arb_rr_pick.sv
// Combinational round-robin first-set search starting at ptr, with wrap.
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [PW-1:0]    pick_idx,
  output logic             pick_valid
);

  logic [PW-1:0] idx;

  // Walk the requesters from ptr upward; the first set bit wins.
  always_comb begin
    pick_oh    = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PW'((32'(ptr) + i) % N_REQ);
      if (!pick_valid && req[idx]) begin
        pick_valid    = 1'b1;
        pick_oh[idx]  = 1'b1;
        pick_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/spi_flash_arb.sv
// SPI flash pad owner: power-up wake command, then round-robin sharing of
// the pads between requesters with an enforced CS-high gap between owners.
module spi_flash_arb
  import spi_flash_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter bit          WAKE_EN     = 1'b1,
  parameter logic [7:0]  WAKE_OPCODE = WAKE_OPCODE_DEF,
  parameter int unsigned WAKE_WAIT   = 36,
  parameter int unsigned CS_GAP      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  input  logic [N_REQ-1:0] req_mosi,
  input  logic [N_REQ-1:0] req_clk,
  input  logic [N_REQ-1:0] req_cs_n,
  output logic             req_miso,
  output logic             busy,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_clk,
  output logic             spi_cs_n
);

  localparam int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(max3(WAKE_CMD_STEPS, WAKE_WAIT, CS_GAP));
  localparam state_t      ST_RESET = WAKE_EN ? ST_WAKE_CMD : ST_IDLE;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] gnt_n;
  logic [PW-1:0]    rr_ptr, rr_n;
  logic [PW-1:0]    owner, owner_n;

  logic [N_REQ-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;

  logic             wk_cs_n, wk_clk, wk_mosi;
  logic [2:0]       bit_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req        (req),
    .ptr        (rr_ptr),
    .pick_oh    (pick_oh),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign bit_idx  = 3'd7 - cnt[3:1];
  assign busy     = (state != ST_IDLE);
  assign req_miso = spi_miso;

  // State, counter, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RESET;
      cnt    <= '0;
      gnt    <= '0;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      gnt    <= gnt_n;
      rr_ptr <= rr_n;
      owner  <= owner_n;
    end
  end

  // Next-state: wake sequencing, arbitration, release and inter-owner gap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt_n   = gnt;
    rr_n    = rr_ptr;
    owner_n = owner;
    unique case (state)
      ST_WAKE_CMD: begin
        if (cnt == CNT_W'(WAKE_CMD_STEPS - 1)) begin
          state_n = ST_WAKE_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_WAKE_WAIT: begin
        if (cnt == CNT_W'(WAKE_WAIT - 1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (pick_valid) begin
          state_n = ST_GRANT;
          gnt_n   = pick_oh;
          owner_n = pick_idx;
        end
      end
      ST_GRANT: begin
        if (!req[owner]) begin
          state_n = ST_GAP;
          gnt_n   = '0;
          cnt_n   = '0;
          rr_n    = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
        end
      end
      ST_GAP: begin
        // Arbitrate on the last gap cycle so the idle window between
        // owners is exactly CS_GAP cycles rather than CS_GAP plus one.
        if (cnt == CNT_W'(CS_GAP - 1)) begin
          cnt_n = '0;
          if (pick_valid) begin
            state_n = ST_GRANT;
            gnt_n   = pick_oh;
            owner_n = pick_idx;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_RESET;
        cnt_n   = '0;
        gnt_n   = '0;
      end
    endcase
  end

  // Registered wake-command pad drive; idle pads in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wk_cs_n <= 1'b1;
      wk_clk  <= 1'b0;
      wk_mosi <= 1'b0;
    end else if (state == ST_WAKE_CMD) begin
      wk_cs_n <= 1'b0;
      wk_clk  <= cnt[0];
      wk_mosi <= WAKE_OPCODE[bit_idx];
    end else begin
      wk_cs_n <= 1'b1;
      wk_clk  <= 1'b0;
      wk_mosi <= 1'b0;
    end
  end

  // Pad mux: granted requester drives the pads combinationally.
  always_comb begin
    spi_cs_n = wk_cs_n;
    spi_clk  = wk_clk;
    spi_mosi = wk_mosi;
    if (state == ST_GRANT) begin
      spi_cs_n = req_cs_n[owner];
      spi_clk  = req_clk[owner];
      spi_mosi = req_mosi[owner];
    end
  end

endmodule
